// File: rtl/retire_pkg.sv
// Shared types and constants for the retire stage: instruction classes, FSM states,
// and the helper that tells which classes may retire on any port.
package retire_pkg;

   localparam int XLEN    = 32;
   localparam int CLASS_W = 3;

   typedef enum logic [CLASS_W-1:0] {
      CLS_ALU   = 3'd0,
      CLS_LOAD  = 3'd1,
      CLS_STORE = 3'd2,
      CLS_CSR   = 3'd3,
      CLS_FENCE = 3'd4,
      CLS_AMO   = 3'd5,
      CLS_FPU   = 3'd6,
      CLS_RSVD  = 3'd7
   } retire_class_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      AMO_WAIT = 2'd2,
      FLUSH    = 2'd3
   } retire_state_e;

   // Classes with no side effects beyond a register write; the reserved encoding behaves as ALU.
   function automatic logic isSimpleClass(input logic [CLASS_W-1:0] cls);
      return (cls == CLS_ALU) || (cls == CLS_LOAD) || (cls == CLS_FPU) || (cls == CLS_RSVD);
   endfunction

endpackage

// File: rtl/retire_prefix_arb.sv
// Prefix-ack chain for the upper retire ports: port i retires only behind port i-1,
// so the first blocked entry stops everything younger than it.
module retire_prefix_arb
   import retire_pkg::*;
#(
   parameter int NrPorts = 2
) (
   input  logic                       ack0_i,
   input  logic                       idle_i,
   input  logic [NrPorts-1:0]         valid_i,
   input  logic [NrPorts-1:0]         ex_i,
   input  logic [NrPorts*CLASS_W-1:0] class_i,
   output logic [NrPorts-1:0]         ack_o
);

   logic unusedPort0;
   assign unusedPort0 = ^{valid_i[0], ex_i[0], class_i[CLASS_W-1:0]};

   always_comb begin
      ack_o    = '0;
      ack_o[0] = ack0_i;
      for (int i = 1; i < NrPorts; i++) begin
         ack_o[i] = ack_o[i-1] & idle_i & valid_i[i] & ~ex_i[i] &
                    isSimpleClass(class_i[i*CLASS_W +: CLASS_W]);
      end
   end

endmodule

// File: rtl/retire_unit.sv
// N-wide in-order retire stage with fence/AMO serialisation and an instret counter.
// Define RETIRE_WATCHDOG_EN to add the head-stall watchdog (watchdog_o).
module retire_unit
   import retire_pkg::*;
#(
   parameter int NrPorts  = 2,
   parameter int CntWidth = 64
`ifdef RETIRE_WATCHDOG_EN
   ,
   parameter int TimeoutCycles = 1024
`endif
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       halt_i,
   input  logic [NrPorts-1:0]         instr_valid_i,
   input  logic [NrPorts-1:0]         instr_ex_i,
   input  logic [NrPorts*CLASS_W-1:0] instr_class_i,
   input  logic [NrPorts*5-1:0]       instr_rd_i,
   input  logic [NrPorts*XLEN-1:0]    instr_result_i,
   input  logic                       no_st_pending_i,
   input  logic                       lsu_ready_i,
   input  logic                       amo_ack_i,
   input  logic [XLEN-1:0]            amo_result_i,
   output logic [NrPorts-1:0]         commit_ack_o,
   output logic [NrPorts-1:0]         we_o,
   output logic [NrPorts*5-1:0]       waddr_o,
   output logic [NrPorts*XLEN-1:0]    wdata_o,
   output logic                       commit_lsu_o,
   output logic                       amo_req_o,
   output logic                       fence_o,
   output logic                       flush_o,
   output logic                       exception_o,
   output logic [CntWidth-1:0]        instret_o
`ifdef RETIRE_WATCHDOG_EN
   ,
   output logic                       watchdog_o
`endif
);

   retire_state_e       state_q, state_d;
   logic                isFence_q, isFence_d;
   logic                amoAckSeen_q, amoAckSeen_d;
   logic [XLEN-1:0]     amoData_q, amoData_d;
   logic [CntWidth-1:0] instret_q, instret_d;

   logic                ack0, we0, commitLsu, amoReq, amoWb;
   logic                head0Ok, amoDone;
   logic [CLASS_W-1:0]  cls0;
   logic [CntWidth-1:0] retireCnt;

   assign cls0    = instr_class_i[CLASS_W-1:0];
   assign head0Ok = instr_valid_i[0] & ~instr_ex_i[0] & ~halt_i;
   // An AMO ack seen while launching is parked in amoAckSeen_q and consumed from AMO_WAIT.
   assign amoDone = amo_ack_i | amoAckSeen_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         isFence_q    <= 1'b0;
         amoAckSeen_q <= 1'b0;
         amoData_q    <= '0;
         instret_q    <= '0;
      end else begin
         state_q      <= state_d;
         isFence_q    <= isFence_d;
         amoAckSeen_q <= amoAckSeen_d;
         amoData_q    <= amoData_d;
         instret_q    <= instret_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      isFence_d    = isFence_q;
      amoAckSeen_d = amoAckSeen_q;
      amoData_d    = amoData_q;
      unique case (state_q)
         IDLE: begin
            if (head0Ok) begin
               if (retire_class_e'(cls0) == CLS_FENCE) begin
                  isFence_d = 1'b1;
                  state_d   = no_st_pending_i ? FLUSH : DRAIN;
               end else if (retire_class_e'(cls0) == CLS_AMO) begin
                  isFence_d    = 1'b0;
                  state_d      = AMO_WAIT;
                  amoAckSeen_d = amo_ack_i;
                  amoData_d    = amo_result_i;
               end
            end
         end
         DRAIN: begin
            if (!halt_i && no_st_pending_i) state_d = FLUSH;
         end
         AMO_WAIT: begin
            if (!halt_i && amoDone) begin
               state_d      = FLUSH;
               amoAckSeen_d = 1'b0;
            end else if (amo_ack_i) begin
               amoAckSeen_d = 1'b1;
               amoData_d    = amo_result_i;
            end
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack0      = 1'b0;
      we0       = 1'b0;
      commitLsu = 1'b0;
      amoReq    = 1'b0;
      amoWb     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (head0Ok) begin
               unique case (retire_class_e'(cls0))
                  CLS_STORE: begin
                     ack0      = lsu_ready_i;
                     commitLsu = lsu_ready_i;
                  end
                  CLS_FENCE: ack0   = no_st_pending_i;
                  CLS_AMO:   amoReq = 1'b1;
                  default: begin
                     ack0 = 1'b1;
                     we0  = 1'b1;
                  end
               endcase
            end
         end
         DRAIN: ack0 = ~halt_i & no_st_pending_i;
         AMO_WAIT: begin
            amoReq = 1'b1;
            if (!halt_i && amoDone) begin
               ack0  = 1'b1;
               we0   = 1'b1;
               amoWb = 1'b1;
            end
         end
         default: ;
      endcase
   end

   retire_prefix_arb #(
      .NrPorts(NrPorts)
   ) u_prefix_arb (
      .ack0_i (ack0),
      .idle_i (state_q == IDLE),
      .valid_i(instr_valid_i),
      .ex_i   (instr_ex_i),
      .class_i(instr_class_i),
      .ack_o  (commit_ack_o)
   );

   always_comb begin
      we_o    = commit_ack_o;
      we_o[0] = we0;
      wdata_o = instr_result_i;
      if (amoWb) wdata_o[XLEN-1:0] = amoAckSeen_q ? amoData_q : amo_result_i;
   end

   always_comb begin
      retireCnt = '0;
      for (int i = 0; i < NrPorts; i++) retireCnt = retireCnt + CntWidth'(commit_ack_o[i]);
      instret_d = instret_q + retireCnt;
   end

   assign waddr_o      = instr_rd_i;
   assign commit_lsu_o = commitLsu;
   assign amo_req_o    = amoReq;
   assign fence_o      = (state_q == FLUSH) & isFence_q;
   assign flush_o      = (state_q == FLUSH);
   assign exception_o  = instr_valid_i[0] & instr_ex_i[0] & ~halt_i;
   assign instret_o    = instret_q;

`ifdef RETIRE_WATCHDOG_EN
   localparam int StallW = $clog2(TimeoutCycles + 1);

   logic [StallW-1:0] stallCnt_q, stallCnt_d;
   logic              watchdog_q, watchdog_d;
   logic              headStall;

   // The counter saturates at the timeout so the sticky flag never depends on wraparound.
   assign headStall = instr_valid_i[0] & ~commit_ack_o[0] & ~halt_i;

   always_comb begin
      stallCnt_d = '0;
      if (headStall) begin
         stallCnt_d = (stallCnt_q == StallW'(TimeoutCycles)) ? stallCnt_q : stallCnt_q + 1'b1;
      end
      watchdog_d = watchdog_q | (stallCnt_d == StallW'(TimeoutCycles));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stallCnt_q <= '0;
         watchdog_q <= 1'b0;
      end else begin
         stallCnt_q <= stallCnt_d;
         watchdog_q <= watchdog_d;
      end
   end

   assign watchdog_o = watchdog_q;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: a 2-port/8-bit-counter instance driven from a vector
// table plus hand sequences, and a 4-port instance for the prefix rule.
`timescale 1ns/1ps
module tb_retire_unit;
   import retire_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [1:0]        aValid, aEx;
   logic [5:0]        aClass;
   logic [9:0]        aRd;
   logic [2*XLEN-1:0] aResult;
   logic              aHalt, aNoSt, aLsuReady, aAmoAck;
   logic [XLEN-1:0]   aAmoResult;
   logic [1:0]        aAck, aWe;
   logic [9:0]        aWaddr;
   logic [2*XLEN-1:0] aWdata;
   logic              aCommitLsu, aAmoReq, aFence, aFlush, aExc;
   logic [7:0]        aInstret;
`ifdef RETIRE_WATCHDOG_EN
   logic              aWatchdog;
`endif

   logic [3:0]        bValid, bEx, bAck, bWe;
   logic [11:0]       bClass;
   logic [19:0]       bRd, bWaddr;
   logic [4*XLEN-1:0] bResult, bWdata;
   logic              bCommitLsu, bAmoReq, bFence, bFlush, bExc;
   logic [63:0]       bInstret;

   retire_unit #(
      .NrPorts (2),
      .CntWidth(8)
`ifdef RETIRE_WATCHDOG_EN
      ,
      .TimeoutCycles(4)
`endif
   ) dutA (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .halt_i         (aHalt),
      .instr_valid_i  (aValid),
      .instr_ex_i     (aEx),
      .instr_class_i  (aClass),
      .instr_rd_i     (aRd),
      .instr_result_i (aResult),
      .no_st_pending_i(aNoSt),
      .lsu_ready_i    (aLsuReady),
      .amo_ack_i      (aAmoAck),
      .amo_result_i   (aAmoResult),
      .commit_ack_o   (aAck),
      .we_o           (aWe),
      .waddr_o        (aWaddr),
      .wdata_o        (aWdata),
      .commit_lsu_o   (aCommitLsu),
      .amo_req_o      (aAmoReq),
      .fence_o        (aFence),
      .flush_o        (aFlush),
      .exception_o    (aExc),
      .instret_o      (aInstret)
`ifdef RETIRE_WATCHDOG_EN
      ,
      .watchdog_o     (aWatchdog)
`endif
   );

   retire_unit #(
      .NrPorts (4),
      .CntWidth(64)
   ) dutB (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .halt_i         (1'b0),
      .instr_valid_i  (bValid),
      .instr_ex_i     (bEx),
      .instr_class_i  (bClass),
      .instr_rd_i     (bRd),
      .instr_result_i (bResult),
      .no_st_pending_i(1'b1),
      .lsu_ready_i    (1'b1),
      .amo_ack_i      (1'b0),
      .amo_result_i   ('0),
      .commit_ack_o   (bAck),
      .we_o           (bWe),
      .waddr_o        (bWaddr),
      .wdata_o        (bWdata),
      .commit_lsu_o   (bCommitLsu),
      .amo_req_o      (bAmoReq),
      .fence_o        (bFence),
      .flush_o        (bFlush),
      .exception_o    (bExc),
      .instret_o      (bInstret)
   );

   typedef struct {
      logic [1:0] valid;
      logic [1:0] ex;
      logic [2:0] c0;
      logic [2:0] c1;
      logic       halt;
      logic       lsuReady;
      logic [1:0] expAck;
      logic [1:0] expWe;
      logic       expLsu;
      logic       expExc;
   } vec_t;

   vec_t       vecs[16];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] expInstret;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      aValid    = v.valid;
      aEx       = v.ex;
      aClass    = {v.c1, v.c0};
      aHalt     = v.halt;
      aLsuReady = v.lsuReady;
      aNoSt     = 1'b1;
      aAmoAck   = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{2'b11, 2'b00, CLS_ALU,   CLS_ALU,   1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0};
      vecs[1]  = '{2'b11, 2'b00, CLS_LOAD,  CLS_FPU,   1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0};
      vecs[2]  = '{2'b01, 2'b00, CLS_ALU,   CLS_ALU,   1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
      vecs[3]  = '{2'b11, 2'b00, CLS_CSR,   CLS_ALU,   1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0};
      vecs[4]  = '{2'b11, 2'b00, CLS_ALU,   CLS_CSR,   1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
      vecs[5]  = '{2'b11, 2'b00, CLS_STORE, CLS_ALU,   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[6]  = '{2'b11, 2'b00, CLS_STORE, CLS_ALU,   1'b0, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0};
      vecs[7]  = '{2'b11, 2'b00, CLS_STORE, CLS_STORE, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
      vecs[8]  = '{2'b11, 2'b01, CLS_ALU,   CLS_ALU,   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
      vecs[9]  = '{2'b11, 2'b10, CLS_ALU,   CLS_ALU,   1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
      vecs[10] = '{2'b11, 2'b00, CLS_ALU,   CLS_ALU,   1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[11] = '{2'b11, 2'b01, CLS_ALU,   CLS_ALU,   1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[12] = '{2'b10, 2'b00, CLS_ALU,   CLS_ALU,   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[13] = '{2'b11, 2'b00, CLS_RSVD,  CLS_RSVD,  1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0};
      vecs[14] = '{2'b11, 2'b00, CLS_ALU,   CLS_FENCE, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
      vecs[15] = '{2'b00, 2'b00, CLS_ALU,   CLS_ALU,   1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};

      rst_n      = 1'b0;
      aValid     = '0;
      aEx        = '0;
      aClass     = '0;
      aRd        = {5'd6, 5'd5};
      aResult    = {32'h2222_2222, 32'h1111_1111};
      aHalt      = 1'b0;
      aNoSt      = 1'b1;
      aLsuReady  = 1'b1;
      aAmoAck    = 1'b0;
      aAmoResult = '0;
      bValid     = '0;
      bEx        = '0;
      bClass     = '0;
      bRd        = '0;
      bResult    = '0;
      expInstret = '0;

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset instret", aInstret, 0);
      checkOutput("reset fence/flush", {aFence, aFlush}, 0);
      checkOutput("reset ack/amoReq/exc", {aAck, aAmoReq, aExc, aCommitLsu}, 0);
      rst_n = 1'b1;

      // Four-port prefix rule and port-0 exception.
      @(negedge clk);
      bValid = 4'b1111; bEx = 4'b0100; #1;
      checkOutput("B ex port2 ack", bAck, 4'b0011);
      checkOutput("B ex port2 we", bWe, 4'b0011);
      @(negedge clk);
      bEx = 4'b0001; #1;
      checkOutput("B ex port0 exc", bExc, 1);
      checkOutput("B ex port0 ack", bAck, 4'b0000);
      @(negedge clk);
      bEx = 4'b0000; #1;
      checkOutput("B all ack", bAck, 4'b1111);
      @(negedge clk);
      bValid = 4'b0000; #1;
      checkOutput("B instret", bInstret, 6);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d ack", i), aAck, vecs[i].expAck);
         checkOutput($sformatf("vec%0d we", i), aWe, vecs[i].expWe);
         checkOutput($sformatf("vec%0d lsu", i), aCommitLsu, vecs[i].expLsu);
         checkOutput($sformatf("vec%0d exc", i), aExc, vecs[i].expExc);
         checkOutput($sformatf("vec%0d amoReq", i), aAmoReq, 0);
         checkOutput($sformatf("vec%0d instret", i), aInstret, expInstret);
         checkOutput($sformatf("vec%0d waddr", i), aWaddr, {5'd6, 5'd5});
         checkOutput($sformatf("vec%0d wdata", i), aWdata, {32'h2222_2222, 32'h1111_1111});
         expInstret = expInstret + 8'($countones(vecs[i].expAck));
      end

      // Fence with stores pending for three cycles.
      @(negedge clk);
      aValid = 2'b01; aEx = '0; aClass = {CLS_ALU, CLS_FENCE}; aNoSt = 1'b0; aHalt = 1'b0;
      #1;
      checkOutput("fence wait0 ack", aAck, 0);
      for (int i = 1; i < 3; i++) begin
         @(negedge clk); #1;
         checkOutput($sformatf("fence drain%0d ack", i), aAck, 0);
      end
      @(negedge clk);
      aNoSt = 1'b1; #1;
      checkOutput("fence drain ack", aAck, 2'b01);
      checkOutput("fence drain we", aWe, 2'b00);
      expInstret = expInstret + 8'd1;
      @(negedge clk);
      aValid = 2'b00; #1;
      checkOutput("fence flush fence/flush", {aFence, aFlush}, 2'b11);
      checkOutput("fence flush ack", aAck, 0);
      @(negedge clk); #1;
      checkOutput("fence idle fence/flush", {aFence, aFlush}, 2'b00);
      checkOutput("fence instret", aInstret, expInstret);

      // AMO acknowledged two cycles after reaching the head.
      @(negedge clk);
      aValid = 2'b01; aClass = {CLS_ALU, CLS_AMO}; aAmoAck = 1'b0; #1;
      checkOutput("amo launch req", aAmoReq, 1);
      checkOutput("amo launch ack", aAck, 0);
      @(negedge clk); #1;
      checkOutput("amo wait ack", aAck, 0);
      @(negedge clk);
      aAmoAck = 1'b1; aAmoResult = 32'h0000_DEAD; #1;
      checkOutput("amo done ack", aAck, 2'b01);
      checkOutput("amo done we", aWe, 2'b01);
      checkOutput("amo done wdata0", aWdata[XLEN-1:0], 32'h0000_DEAD);
      expInstret = expInstret + 8'd1;
      @(negedge clk);
      aAmoAck = 1'b0; aValid = 2'b00; #1;
      checkOutput("amo flush fence/flush", {aFence, aFlush}, 2'b01);
      @(negedge clk); #1;
      checkOutput("amo instret", aInstret, expInstret);

      // AMO ack arriving in the launch cycle is held until AMO_WAIT.
      @(negedge clk);
      aValid = 2'b01; aClass = {CLS_ALU, CLS_AMO}; aAmoAck = 1'b1; aAmoResult = 32'h0000_BEEF; #1;
      checkOutput("amo early launch ack", aAck, 0);
      @(negedge clk);
      aAmoAck = 1'b0; aAmoResult = 32'h0; #1;
      checkOutput("amo early ack", aAck, 2'b01);
      checkOutput("amo early wdata0", aWdata[XLEN-1:0], 32'h0000_BEEF);
      expInstret = expInstret + 8'd1;
      @(negedge clk);
      aValid = 2'b00; #1;
      checkOutput("amo early flush", aFlush, 1);

      // Halt freezes DRAIN; the fence retires once halt drops.
      @(negedge clk);
      aValid = 2'b01; aClass = {CLS_ALU, CLS_FENCE}; aNoSt = 1'b0; #1;
      @(negedge clk);
      aHalt = 1'b1; aNoSt = 1'b1; #1;
      checkOutput("halt drain ack", aAck, 0);
      @(negedge clk); #1;
      checkOutput("halt drain hold ack", aAck, 0);
      @(negedge clk);
      aHalt = 1'b0; #1;
      checkOutput("halt release ack", aAck, 2'b01);
      expInstret = expInstret + 8'd1;
      @(negedge clk);
      aValid = 2'b00; #1;
      checkOutput("halt flush fence", aFence, 1);
      @(negedge clk); #1;
      checkOutput("halt instret", aInstret, expInstret);

      // Reset in the middle of AMO_WAIT abandons it.
      @(negedge clk);
      aValid = 2'b01; aClass = {CLS_ALU, CLS_AMO}; aAmoAck = 1'b0;
      @(negedge clk); #1;
      checkOutput("midreset wait req", aAmoReq, 1);
      rst_n = 1'b0; aValid = 2'b00;
      @(negedge clk); #1;
      checkOutput("midreset instret", aInstret, 0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      checkOutput("midreset idle req", aAmoReq, 0);

      // Counter wrap: 127 double retires, one single, then a double.
      @(negedge clk);
      aValid = 2'b11; aClass = {CLS_ALU, CLS_ALU};
      repeat (127) @(negedge clk);
      aValid = 2'b01;
      @(negedge clk); #1;
      checkOutput("wrap at 255", aInstret, 8'd255);
      aValid = 2'b11;
      @(negedge clk); #1;
      checkOutput("wrap to 1", aInstret, 8'd1);
      aValid = 2'b00;

`ifdef RETIRE_WATCHDOG_EN
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; aValid = 2'b01; aClass = {CLS_ALU, CLS_STORE}; aLsuReady = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("watchdog before timeout", aWatchdog, 0);
      @(negedge clk); #1;
      checkOutput("watchdog at timeout", aWatchdog, 1);
      aValid = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("watchdog sticky", aWatchdog, 1);
      rst_n = 1'b0;
      @(negedge clk); #1;
      checkOutput("watchdog reset", aWatchdog, 0);
      rst_n = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
